// File: rtl/conv3x3_engine_if.sv
// Register-bus bundle for conv3x3_engine: strobe/address/data in, read data and irq out.
interface conv3x3_engine_if;
    logic [3:0]  addr;
    logic        en;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, en, we, din, input dout, irq);
    modport slave  (input addr, en, we, din, output dout, irq);
endinterface

// File: rtl/conv3x3_engine.sv
// Streaming 3x3 convolution engine behind a small register bus.
// Optional ReLU clamp is built when CONV3X3_RELU_EN is defined.
module conv3x3_engine #(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128,
    parameter int PIX_W      = 8,
    parameter int COEF_W     = 8
) (
    input logic clk,
    input logic rst_n,
    conv3x3_engine_if.slave bus
);
    localparam int LB_N   = 2 * IMG_WIDTH + 3;
    localparam int PROD_W = PIX_W + COEF_W + 1;
    localparam int ACC_W  = PIX_W + COEF_W + 4;
    localparam int W      = IMG_WIDTH;

    logic [PIX_W-1:0]         lb [LB_N];
    logic signed [COEF_W-1:0] wt [9];
    logic [4:0]               shift;
    logic                     irq_en;
    logic                     relu_en;
    logic [15:0]              col;
    logic [15:0]              row;
    logic signed [PROD_W-1:0] prod [9];
    logic signed [PROD_W-1:0] prod_d [9];
    logic [PIX_W-1:0]         pix [9];
    logic                     s1_valid;
    logic                     s2_valid;
    logic [31:0]              result;
    logic                     res_valid;
    logic                     overrun;
    logic                     frame_done;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    logic [31:0]              res_d;
    logic [31:0]              rd_data;
    logic                     unused_din;

    wire wr       = bus.en & bus.we;
    wire rd       = bus.en & ~bus.we;
    wire push     = wr && bus.addr == 4'd0;
    wire clr      = wr && bus.addr == 4'd2;
    wire wr_stat  = wr && bus.addr == 4'd12;
    wire wr_ctrl  = wr && bus.addr == 4'd13;
    wire wr_wt    = wr && bus.addr >= 4'd3 && bus.addr <= 4'd11;
    wire rd_res   = rd && bus.addr == 4'd1;
    wire col_last = col == 16'(IMG_WIDTH - 1);
    wire row_last = row == 16'(IMG_HEIGHT - 1);
    wire win_vld  = push && col >= 16'd2 && row >= 16'd2;

    wire [31:0] status = {28'd0, frame_done, s1_valid | s2_valid,
                          overrun, res_valid};
    wire [31:0] ctrl   = {22'd0, relu_en, irq_en, 3'd0, shift};

    assign unused_din = ^bus.din;
    assign bus.irq    = frame_done & irq_en;

    // Window as it will look once the incoming pixel has shifted in.
    always_comb begin
        pix[8] = bus.din[PIX_W-1:0];
        pix[7] = lb[0];
        pix[6] = lb[1];
        pix[5] = lb[W-1];
        pix[4] = lb[W];
        pix[3] = lb[W+1];
        pix[2] = lb[2*W-1];
        pix[1] = lb[2*W];
        pix[0] = lb[2*W+1];
        for (int i = 0; i < 9; i++)
            prod_d[i] = PROD_W'($signed({1'b0, pix[i]})) * PROD_W'(wt[i]);
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < 9; i++)
            acc = acc + ACC_W'(prod[i]);
        shifted = acc >>> shift;
        res_d   = 32'(shifted);
`ifdef CONV3X3_RELU_EN
        if (relu_en && shifted < 0)
            res_d = '0;
`endif
    end

    always_comb begin
        rd_data = '0;
        case (bus.addr)
            4'd1:    rd_data = result;
            4'd12:   rd_data = status;
            4'd13:   rd_data = ctrl;
            4'd14:   rd_data = {row, col};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LB_N; i++) lb[i] <= '0;
            for (int i = 0; i < 9; i++) prod[i] <= '0;
            col        <= '0;
            row        <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            result     <= '0;
            res_valid  <= 1'b0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < LB_N; i++) lb[i] <= '0;
            for (int i = 0; i < 9; i++) prod[i] <= '0;
            col        <= '0;
            row        <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            result     <= '0;
            res_valid  <= 1'b0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (wr_stat) begin
                if (bus.din[1]) overrun    <= 1'b0;
                if (bus.din[3]) frame_done <= 1'b0;
            end
            if (push) begin
                lb[0] <= bus.din[PIX_W-1:0];
                for (int i = 1; i < LB_N; i++) lb[i] <= lb[i-1];
                col <= col_last ? 16'd0 : col + 16'd1;
                if (col_last) row <= row_last ? 16'd0 : row + 16'd1;
                if (col_last && row_last) frame_done <= 1'b1;
            end
            s1_valid <= win_vld;
            if (win_vld) prod <= prod_d;
            s2_valid <= s1_valid;
            // A landing result wins over a same-cycle read of the old one.
            if (s1_valid) begin
                result    <= res_d;
                res_valid <= 1'b1;
                if (res_valid) overrun <= 1'b1;
            end else if (rd_res) begin
                res_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) wt[i] <= '0;
            shift   <= '0;
            irq_en  <= 1'b0;
            relu_en <= 1'b0;
        end else begin
            if (wr_wt) wt[bus.addr - 4'd3] <= bus.din[COEF_W-1:0];
            if (wr_ctrl) begin
                shift  <= bus.din[4:0];
                irq_en <= bus.din[8];
`ifdef CONV3X3_RELU_EN
                relu_en <= bus.din[9];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.dout <= '0;
        else        bus.dout <= rd ? rd_data : '0;
    end
endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine on a 4x4 frame with a reference model.
module tb_conv3x3_engine;
    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    conv3x3_engine_if bus();

    conv3x3_engine #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8), .COEF_W(8))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int img [H][W];
    int wm [9];
    int msh = 0;
    bit mrelu = 1'b0;
    int mr = 0;
    int mc = 0;

    typedef struct {
        bit          we;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [10];

`ifdef CONV3X3_RELU_EN
    localparam logic [31:0] CTRL_EXP = 32'h0000_031F;
`else
    localparam logic [31:0] CTRL_EXP = 32'h0000_011F;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a; bus.din = d; bus.we = 1'b1; bus.en = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a; bus.we = 1'b0; bus.en = 1'b1;
        @(posedge clk); #1;
        bus.en = 1'b0;
        d = bus.dout;
    endtask

    function automatic int ref_conv(input int r, input int c);
        int acc = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                acc += wm[dr*3+dc] * img[r-2+dr][c-2+dc];
        acc = acc >>> msh;
        if (mrelu && acc < 0) acc = 0;
        return acc;
    endfunction

    task automatic push(input int v, output bit vld, output int exp);
        wr(4'd0, 32'(v));
        img[mr][mc] = v;
        vld = (mr >= 2 && mc >= 2);
        exp = vld ? ref_conv(mr, mc) : 0;
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr + 1) % H;
        end
    endtask

    task automatic clear_dut();
        wr(4'd2, 32'd0);
        mr = 0; mc = 0;
    endtask

    task automatic load_w();
        for (int i = 0; i < 9; i++) wr(4'(3 + i), 32'(wm[i]));
    endtask

    task automatic push_seq(input int n);
        bit v; int e;
        for (int k = 1; k <= n; k++) push(k, v, e);
    endtask

    initial begin
        logic [31:0] d;
        bit v;
        int e;
        int nres;

        bus.addr = '0; bus.din = '0; bus.we = 1'b0; bus.en = 1'b0;
        for (int i = 0; i < 9; i++) wm[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        chk("rst_dout", bus.dout, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        rd(4'd12, d); chk("rst_status", d, 32'd0);
        rd(4'd13, d); chk("rst_ctrl", d, 32'd0);
        rd(4'd14, d); chk("rst_pos", d, 32'd0);
        rd(4'd1, d);  chk("rst_result", d, 32'd0);

        tbl[0] = '{1'b1, 4'd13, 32'h0000_FF1F, 32'd0};
        tbl[1] = '{1'b0, 4'd13, 32'd0, CTRL_EXP};
        tbl[2] = '{1'b1, 4'd3,  32'h0000_0055, 32'd0};
        tbl[3] = '{1'b0, 4'd3,  32'd0, 32'd0};
        tbl[4] = '{1'b0, 4'd15, 32'd0, 32'd0};
        tbl[5] = '{1'b0, 4'd0,  32'd0, 32'd0};
        tbl[6] = '{1'b0, 4'd2,  32'd0, 32'd0};
        tbl[7] = '{1'b0, 4'd12, 32'd0, 32'd0};
        tbl[8] = '{1'b1, 4'd13, 32'd0, 32'd0};
        tbl[9] = '{1'b0, 4'd13, 32'd0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].we) wr(tbl[i].a, tbl[i].d);
            else begin
                rd(tbl[i].a, d);
                chk($sformatf("tbl%0d", i), d, tbl[i].exp);
            end
        end

        // Frame of 1..16, all weights 1, irq enabled.
        for (int i = 0; i < 9; i++) wm[i] = 1;
        load_w();
        msh = 0;
        wr(4'd13, 32'h100);
        clear_dut();
        nres = 0;
        for (int k = 1; k <= 16; k++) begin
            push(k, v, e);
            rd(4'd12, d);
            chk($sformatf("lat1_px%0d", k), d, (v ? 32'h4 : 32'h0) | (k == 16 ? 32'h8 : 32'h0));
            rd(4'd12, d);
            chk($sformatf("lat2_px%0d", k), d, (v ? 32'h5 : 32'h0) | (k == 16 ? 32'h8 : 32'h0));
            if (d[0]) begin
                nres++;
                rd(4'd1, d);
                chk($sformatf("res_px%0d", k), d, 32'(e));
                if (k == 11) chk("first_res", d, 32'd54);
                @(posedge clk); #1;
                chk("dout_idle", bus.dout, 32'd0);
            end
        end
        chk("res_count", 32'(nres), 32'd4);
        rd(4'd12, d); chk("frame_done", d, 32'h8);
        chk("irq_on", {31'd0, bus.irq}, 32'd1);
        wr(4'd12, 32'h8);
        chk("irq_off", {31'd0, bus.irq}, 32'd0);
        rd(4'd14, d); chk("pos_wrap", d, 32'd0);

        // Two results without a read in between.
        clear_dut();
        push_seq(12);
        repeat (2) @(posedge clk);
        rd(4'd12, d); chk("overrun_st", d, 32'h3);
        rd(4'd1, d);  chk("overrun_res", d, 32'd63);
        wr(4'd12, 32'h2);
        rd(4'd12, d); chk("w1c_st", d, 32'h0);

        // Arithmetic shift.
        wr(4'd13, 32'd2);
        msh = 2;
        clear_dut();
        push_seq(11);
        repeat (2) @(posedge clk);
        rd(4'd1, d); chk("shift2", d, 32'd13);

        // Negative result, then clamp when available.
        for (int i = 0; i < 9; i++) wm[i] = (i == 4) ? -1 : 0;
        load_w();
        wr(4'd13, 32'd0);
        msh = 0;
        clear_dut();
        for (int k = 1; k <= 11; k++) push(k == 6 ? 5 : k, v, e);
        repeat (2) @(posedge clk);
        rd(4'd1, d); chk("neg_res", d, 32'hFFFF_FFFB);
`ifdef CONV3X3_RELU_EN
        wr(4'd13, 32'h200);
        clear_dut();
        for (int k = 1; k <= 11; k++) push(k == 6 ? 5 : k, v, e);
        repeat (2) @(posedge clk);
        rd(4'd1, d); chk("relu_res", d, 32'h0);
        wr(4'd13, 32'd0);
`endif

        // Reset in flight.
        for (int i = 0; i < 9; i++) wm[i] = 1;
        load_w();
        clear_dut();
        push_seq(11);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_dout", bus.dout, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 9; i++) wm[i] = 0;
        msh = 0; mr = 0; mc = 0;
        repeat (3) @(posedge clk);
        rd(4'd12, d); chk("rst_mid_st", d, 32'd0);
        rd(4'd1, d);  chk("rst_mid_res", d, 32'd0);
        push_seq(11);
        repeat (2) @(posedge clk);
        rd(4'd12, d); chk("rst_w_st", d, 32'h1);
        rd(4'd1, d);  chk("rst_w_res", d, 32'd0);

        // Randomized frames against the model.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 9; i++) wm[i] = int'($urandom_range(0, 255)) - 128;
            load_w();
            msh = int'($urandom_range(0, 6));
`ifdef CONV3X3_RELU_EN
            mrelu = 1'($urandom_range(0, 1));
`endif
            wr(4'd13, 32'(msh) | (mrelu ? 32'h200 : 32'h0));
            clear_dut();
            for (int k = 0; k < W * H; k++) begin
                push(int'($urandom_range(0, 255)), v, e);
                repeat (2) @(posedge clk);
                rd(4'd12, d);
                chk("rnd_vld", {31'd0, d[0]}, {31'd0, v});
                if (v) begin
                    rd(4'd1, d);
                    chk($sformatf("rnd_f%0d_px%0d", f, k), d, 32'(e));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
